// File: rtl/controlpath.sv
// controlpath -- main control and ALU-control decoder for the 32-bit MIPS datapath.
//
// The opcode (and, for R-type, the function field) is decoded combinationally.
// The resulting steering flags, branch flag and 3-bit ALU operation are
// registered on the rising clock edge. The PC-source select combines the
// registered branch flag with the live ALU zero flag.
//
// Ports:
//   clk           in   1  system clock, rising edge active
//   reset         in   1  asynchronous, active-high reset
//   instruccion   in   6  opcode field, instruction bits [31:26]
//   CampoFuncion  in   6  function field, instruction bits [5:0] (R-type only)
//   zero          in   1  ALU zero flag from the datapath
//   RegDest       out  1  1 = write register is rd, 0 = rt
//   LeerMem       out  1  data-memory read enable
//   MemaReg       out  1  1 = register write data from memory, 0 = from ALU
//   EscrMem       out  1  data-memory write enable
//   FuenteALU     out  1  1 = ALU operand B is the sign-extended immediate
//   EscrReg       out  1  register-file write enable
//   selFuentePc   out  1  1 = PC loads the branch target, 0 = PC+4
//   controldeALU  out  3  ALU operation code
module controlpath (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instruccion,
  input  logic [5:0] CampoFuncion,
  input  logic       zero,
  output logic       RegDest,
  output logic       LeerMem,
  output logic       MemaReg,
  output logic       EscrMem,
  output logic       FuenteALU,
  output logic       EscrReg,
  output logic       selFuentePc,
  output logic [2:0] controldeALU
);

  // Opcode encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type function encodings
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUOp classes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic       regDest_s;
  logic       fuenteAlu_s;
  logic       memaReg_s;
  logic       escrReg_s;
  logic       leerMem_s;
  logic       escrMem_s;
  logic       branch_s;
  logic [1:0] aluOp_s;
  logic [2:0] aluCtl_s;

  logic       regDest_r;
  logic       fuenteAlu_r;
  logic       memaReg_r;
  logic       escrReg_r;
  logic       leerMem_r;
  logic       escrMem_r;
  logic       branch_r;
  logic [2:0] aluCtl_r;

  // Main decode: opcode to steering flags, branch flag and ALUOp class.
  // An unknown or X opcode matches no item and lands on the no-op default.
  always_comb begin
    regDest_s   = 1'b0;
    fuenteAlu_s = 1'b0;
    memaReg_s   = 1'b0;
    escrReg_s   = 1'b0;
    leerMem_s   = 1'b0;
    escrMem_s   = 1'b0;
    branch_s    = 1'b0;
    aluOp_s     = ALUOP_ADD;
    case (instruccion)
      OP_RTYPE: begin
        regDest_s = 1'b1;
        escrReg_s = 1'b1;
        aluOp_s   = ALUOP_FUNCT;
      end
      OP_LW: begin
        fuenteAlu_s = 1'b1;
        memaReg_s   = 1'b1;
        escrReg_s   = 1'b1;
        leerMem_s   = 1'b1;
      end
      OP_SW: begin
        fuenteAlu_s = 1'b1;
        escrMem_s   = 1'b1;
      end
      OP_BEQ: begin
        branch_s = 1'b1;
        aluOp_s  = ALUOP_SUB;
      end
      default: begin
        regDest_s   = 1'b0;
        fuenteAlu_s = 1'b0;
        memaReg_s   = 1'b0;
        escrReg_s   = 1'b0;
        leerMem_s   = 1'b0;
        escrMem_s   = 1'b0;
        branch_s    = 1'b0;
        aluOp_s     = ALUOP_ADD;
      end
    endcase
  end

  // ALU control: the function field is only looked at for the R-type class,
  // so an undriven funct on lw/sw/beq/no-op never reaches the output.
  always_comb begin
    aluCtl_s = ALU_ADD;
    case (aluOp_s)
      ALUOP_ADD: aluCtl_s = ALU_ADD;
      ALUOP_SUB: aluCtl_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (CampoFuncion)
          FN_ADD:  aluCtl_s = ALU_ADD;
          FN_SUB:  aluCtl_s = ALU_SUB;
          FN_AND:  aluCtl_s = ALU_AND;
          FN_OR:   aluCtl_s = ALU_OR;
          FN_SLT:  aluCtl_s = ALU_SLT;
          default: aluCtl_s = ALU_ADD;
        endcase
      end
      default: aluCtl_s = ALU_ADD;
    endcase
  end

  // Decode register: async clear, otherwise captures the current decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regDest_r   <= 1'b0;
      fuenteAlu_r <= 1'b0;
      memaReg_r   <= 1'b0;
      escrReg_r   <= 1'b0;
      leerMem_r   <= 1'b0;
      escrMem_r   <= 1'b0;
      branch_r    <= 1'b0;
      aluCtl_r    <= 3'b000;
    end else begin
      regDest_r   <= regDest_s;
      fuenteAlu_r <= fuenteAlu_s;
      memaReg_r   <= memaReg_s;
      escrReg_r   <= escrReg_s;
      leerMem_r   <= leerMem_s;
      escrMem_r   <= escrMem_s;
      branch_r    <= branch_s;
      aluCtl_r    <= aluCtl_s;
    end
  end

  assign RegDest      = regDest_r;
  assign FuenteALU    = fuenteAlu_r;
  assign MemaReg      = memaReg_r;
  assign EscrReg      = escrReg_r;
  assign LeerMem      = leerMem_r;
  assign EscrMem      = escrMem_r;
  assign controldeALU = aluCtl_r;

  // Branch is taken within the same cycle the ALU reports equality, so zero
  // is deliberately not registered here.
  assign selFuentePc = branch_r & zero;

endmodule

// File: tb/tb_controlpath.sv
module tb_controlpath;

  logic       clk;
  logic       reset;
  logic [5:0] instruccion;
  logic [5:0] CampoFuncion;
  logic       zero;
  logic       RegDest;
  logic       LeerMem;
  logic       MemaReg;
  logic       EscrMem;
  logic       FuenteALU;
  logic       EscrReg;
  logic       selFuentePc;
  logic [2:0] controldeALU;

  int checks;
  int failures;

  controlpath dut (
    .clk          (clk),
    .reset        (reset),
    .instruccion  (instruccion),
    .CampoFuncion (CampoFuncion),
    .zero         (zero),
    .RegDest      (RegDest),
    .LeerMem      (LeerMem),
    .MemaReg      (MemaReg),
    .EscrMem      (EscrMem),
    .FuenteALU    (FuenteALU),
    .EscrReg      (EscrReg),
    .selFuentePc  (selFuentePc),
    .controldeALU (controldeALU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {RegDest,LeerMem,MemaReg,EscrMem,FuenteALU,EscrReg,selFuentePc,controldeALU}
  logic [9:0] outs;
  assign outs = {RegDest, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg,
                 selFuentePc, controldeALU};

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (RD,LM,MR,EM,FA,ER,PC,ALU)", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //                name         op          fn          z     RD LM MR EM FA ER PC ALU
    vecs[0]  = '{"r_add",   6'b000000, 6'b100000, 1'b0, 10'b1_0_0_0_0_1_0_010};
    vecs[1]  = '{"r_sub",   6'b000000, 6'b100010, 1'b0, 10'b1_0_0_0_0_1_0_110};
    vecs[2]  = '{"r_and",   6'b000000, 6'b100100, 1'b0, 10'b1_0_0_0_0_1_0_000};
    vecs[3]  = '{"r_or",    6'b000000, 6'b100101, 1'b0, 10'b1_0_0_0_0_1_0_001};
    vecs[4]  = '{"r_slt",   6'b000000, 6'b101010, 1'b0, 10'b1_0_0_0_0_1_0_111};
    vecs[5]  = '{"r_other", 6'b000000, 6'b111111, 1'b0, 10'b1_0_0_0_0_1_0_010};
    vecs[6]  = '{"r_zero1", 6'b000000, 6'b100010, 1'b1, 10'b1_0_0_0_0_1_0_110};
    vecs[7]  = '{"lw",      6'b100011, 6'bxxxxxx, 1'b0, 10'b0_1_1_0_1_1_0_010};
    vecs[8]  = '{"sw",      6'b101011, 6'bxxxxxx, 1'b1, 10'b0_0_0_1_1_0_0_010};
    vecs[9]  = '{"beq_z0",  6'b000100, 6'bxxxxxx, 1'b0, 10'b0_0_0_0_0_0_0_110};
    vecs[10] = '{"beq_z1",  6'b000100, 6'bxxxxxx, 1'b1, 10'b0_0_0_0_0_0_1_110};
    vecs[11] = '{"nop_j",   6'b000010, 6'b100010, 1'b1, 10'b0_0_0_0_0_0_0_010};
    vecs[12] = '{"nop_ff",  6'b111111, 6'b101010, 1'b0, 10'b0_0_0_0_0_0_0_010};

    // Reset held across several edges with an R-type on the inputs and zero=1
    reset        = 1'b1;
    instruccion  = 6'b000000;
    CampoFuncion = 6'b100000;
    zero         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", outs, 10'b0);

    // Release reset away from an edge
    #3;
    reset = 1'b0;

    // Table-driven sweep: one edge per vector, sampled 1 time unit after it
    for (int i = 0; i < 13; i++) begin
      instruccion  = vecs[i].op;
      CampoFuncion = vecs[i].fn;
      zero         = vecs[i].z;
      @(posedge clk);
      #1;
      check(vecs[i].name, outs, vecs[i].exp);
    end

    // beq: zero rising mid-cycle takes effect without an edge
    instruccion  = 6'b000100;
    CampoFuncion = 6'bxxxxxx;
    zero         = 1'b0;
    @(posedge clk);
    #1;
    check("beq_pre", outs, 10'b0_0_0_0_0_0_0_110);
    #2;
    zero = 1'b1;
    #1;
    check("beq_zero_live", outs, 10'b0_0_0_0_0_0_1_110);
    // Switching to lw clears the branch after the next edge even with zero=1
    instruccion = 6'b100011;
    #1;
    check("beq_hold_before_edge", outs, 10'b0_0_0_0_0_0_1_110);
    @(posedge clk);
    #1;
    check("lw_after_beq", outs, 10'b0_1_1_0_1_1_0_010);

    // Latency: opcode changes between edges, outputs hold until the edge
    instruccion  = 6'b000000;
    CampoFuncion = 6'b100101;
    zero         = 1'b0;
    @(posedge clk);
    #1;
    check("r_or_load", outs, 10'b1_0_0_0_0_1_0_001);
    #3;
    instruccion = 6'b000010;
    #1;
    check("latency_hold", outs, 10'b1_0_0_0_0_1_0_001);
    @(posedge clk);
    #1;
    check("latency_update", outs, 10'b0_0_0_0_0_0_0_010);

    // Asynchronous reset mid-cycle clears without a clock edge
    instruccion  = 6'b000100;
    zero         = 1'b1;
    @(posedge clk);
    #1;
    check("beq_before_rst", outs, 10'b0_0_0_0_0_0_1_110);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs, 10'b0);
    #2;
    reset = 1'b0;
    #1;
    check("after_release_no_edge", outs, 10'b0);
    // First edge after release loads the current decode
    @(posedge clk);
    #1;
    check("first_edge_after_rst", outs, 10'b0_0_0_0_0_0_1_110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
